// File: rtl/swap_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : swap_checker                                               |
// | Description : Observer verifying each sampled (A,B) pair is the exchange |
// |               of the previous one; counts swaps and mismatches.          |
// |               Optional first-error capture: SWAP_CHK_FIRST_ERR_EN.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module swap_checker #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
`ifdef SWAP_CHK_FIRST_ERR_EN
  output logic [CNT_W-1:0] swap_count,
  output logic             first_valid,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH-1:0] first_exp_a
`else
  output logic [CNT_W-1:0] swap_count
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_prev_a;
  logic [WIDTH-1:0] r_prev_b;
  logic             r_mismatch;
  logic [ERR_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_swap_count;
  logic             w_restart;
  logic             w_compare;
  logic             w_match;
  logic             w_err_sat;

  always_ff @(posedge clk) begin
    if (rst || clear) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = rst || clear;
    w_compare   = 1'b0;
    w_match     = (a_in == r_prev_b) && (b_in == r_prev_a);
    w_err_sat   = &r_err_count;
    case (r_state)
      IDLE:    if (en) w_state_nxt = ARMED;
      ARMED:   w_compare = en;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The reference pair always tracks the latest sample so a single fault
  // does not cascade into errors on every following sample.
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_prev_a     <= '0;
      r_prev_b     <= '0;
      r_mismatch   <= 1'b0;
      r_err_count  <= '0;
      r_swap_count <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (en) begin
        r_prev_a <= a_in;
        r_prev_b <= b_in;
      end
      if (w_compare) begin
        if (w_match) begin
          r_swap_count <= r_swap_count + 1'b1;
        end else begin
          r_mismatch <= 1'b1;
          if (!w_err_sat) r_err_count <= r_err_count + 1'b1;
        end
      end
    end
  end

`ifdef SWAP_CHK_FIRST_ERR_EN
  logic             r_first_valid;
  logic [WIDTH-1:0] r_first_a;
  logic [WIDTH-1:0] r_first_b;
  logic [WIDTH-1:0] r_first_exp_a;

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_first_valid <= 1'b0;
      r_first_a     <= '0;
      r_first_b     <= '0;
      r_first_exp_a <= '0;
    end else if (w_compare && !w_match && !r_first_valid) begin
      r_first_valid <= 1'b1;
      r_first_a     <= a_in;
      r_first_b     <= b_in;
      r_first_exp_a <= r_prev_b;
    end
  end

  assign first_valid = r_first_valid;
  assign first_a     = r_first_a;
  assign first_b     = r_first_b;
  assign first_exp_a = r_first_exp_a;
`endif

  assign locked     = (r_state == ARMED);
  assign mismatch   = r_mismatch;
  assign err_count  = r_err_count;
  assign swap_count = r_swap_count;

endmodule
`default_nettype wire

// File: tb/tb_swap_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_swap_checker                                            |
// | Description : Directed self-checking bench for swap_checker (default and |
// |               narrow-counter instances share one stimulus stream).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_swap_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;

  logic        locked, mismatch;
  logic [7:0]  err_count;
  logic [15:0] swap_count;
  logic        n_locked, n_mismatch;
  logic [1:0]  n_err_count;
  logic [1:0]  n_swap_count;
`ifdef SWAP_CHK_FIRST_ERR_EN
  logic        first_valid, n_first_valid;
  logic [7:0]  first_a, first_b, first_exp_a;
  logic [7:0]  n_first_a, n_first_b, n_first_exp_a;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  swap_checker #(.WIDTH(8), .ERR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .clear(clear),
    .locked(locked), .mismatch(mismatch), .err_count(err_count),
`ifdef SWAP_CHK_FIRST_ERR_EN
    .first_valid(first_valid), .first_a(first_a), .first_b(first_b),
    .first_exp_a(first_exp_a),
`endif
    .swap_count(swap_count)
  );

  // Narrow counters to reach saturation and wrap in a few samples.
  swap_checker #(.WIDTH(8), .ERR_W(2), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .clear(clear),
    .locked(n_locked), .mismatch(n_mismatch), .err_count(n_err_count),
`ifdef SWAP_CHK_FIRST_ERR_EN
    .first_valid(n_first_valid), .first_a(n_first_a), .first_b(n_first_b),
    .first_exp_a(n_first_exp_a),
`endif
    .swap_count(n_swap_count)
  );

  // Drive on the falling edge, return #1 after the rising edge that samples.
  task automatic cycle(input logic e, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    @(negedge clk);
    en = e; a_in = a; b_in = b; clear = c;
    @(posedge clk);
    #1;
    en = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    cycle(1'b0, 8'd0, 8'd0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b1, 8'd3, 8'd4, 1'b0);
    cycle(1'b0, 8'd0, 8'd0, 1'b0);
    rst = 1'b0;
    vectors++;
    if (locked !== 1'b0 || mismatch !== 1'b0 || err_count !== 8'd0 || swap_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset: locked=%b mismatch=%b err=%0d swap=%0d, need 0/0/0/0",
               locked, mismatch, err_count, swap_count);
    end
`ifdef SWAP_CHK_FIRST_ERR_EN
    vectors++;
    if (first_valid !== 1'b0 || first_a !== 8'd0 || first_b !== 8'd0 || first_exp_a !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_first: valid=%b a=%0d b=%0d exp=%0d, need all 0",
               first_valid, first_a, first_b, first_exp_a);
    end
`endif
  endtask

  task automatic test_swap_chain();
    logic [15:0] exp_swap [3] = '{16'd0, 16'd1, 16'd2};
    logic [7:0]  va [3] = '{8'd5, 8'd6, 8'd5};
    logic [7:0]  vb [3] = '{8'd6, 8'd5, 8'd6};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, va[i], vb[i], 1'b0);
      vectors++;
      if (locked !== 1'b1 || mismatch !== 1'b0 || swap_count !== exp_swap[i] || err_count !== 8'd0) begin
        miscompares++;
        $display("FAIL swap_chain[%0d]: locked=%b mismatch=%b swap=%0d err=%0d, need 1/0/%0d/0",
                 i, locked, mismatch, swap_count, err_count, exp_swap[i]);
      end
    end
  endtask

  task automatic test_mismatch();
    do_clear();
    cycle(1'b1, 8'd5, 8'd6, 1'b0);
    cycle(1'b1, 8'd5, 8'd6, 1'b0);
    vectors++;
    if (mismatch !== 1'b1 || err_count !== 8'd1 || swap_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mismatch_hit: mismatch=%b err=%0d swap=%0d, need 1/1/0",
               mismatch, err_count, swap_count);
    end
    cycle(1'b1, 8'd6, 8'd5, 1'b0);
    vectors++;
    if (mismatch !== 1'b0 || err_count !== 8'd1 || swap_count !== 16'd1) begin
      miscompares++;
      $display("FAIL mismatch_recover: mismatch=%b err=%0d swap=%0d, need 0/1/1",
               mismatch, err_count, swap_count);
    end
  endtask

  task automatic test_gaps();
    do_clear();
    cycle(1'b1, 8'd5, 8'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      // Garbage on the data bus must be ignored while en is low.
      cycle(1'b0, 8'hAA, 8'h55, 1'b0);
      vectors++;
      if (locked !== 1'b1 || mismatch !== 1'b0 || swap_count !== 16'd0 || err_count !== 8'd0) begin
        miscompares++;
        $display("FAIL gap_idle[%0d]: locked=%b mismatch=%b swap=%0d err=%0d, need 1/0/0/0",
                 i, locked, mismatch, swap_count, err_count);
      end
    end
    cycle(1'b1, 8'd6, 8'd5, 1'b0);
    vectors++;
    if (mismatch !== 1'b0 || swap_count !== 16'd1 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL gap_swap: mismatch=%b swap=%0d err=%0d, need 0/1/0",
               mismatch, swap_count, err_count);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_n [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_clear();
    cycle(1'b1, 8'd1, 8'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'd1, 8'd2, 1'b0);
      vectors++;
      if (n_err_count !== exp_n[i] || n_mismatch !== 1'b1 || mismatch !== 1'b1 ||
          err_count !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL saturate[%0d]: n_err=%0d n_mm=%b mm=%b err=%0d, need %0d/1/1/%0d",
                 i, n_err_count, n_mismatch, mismatch, err_count, exp_n[i], i + 1);
      end
    end
    cycle(1'b0, 8'd0, 8'd0, 1'b0);
    vectors++;
    if (mismatch !== 1'b0 || n_mismatch !== 1'b0 || n_err_count !== 2'd3) begin
      miscompares++;
      $display("FAIL saturate_end: mm=%b n_mm=%b n_err=%0d, need 0/0/3",
               mismatch, n_mismatch, n_err_count);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_n [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_clear();
    cycle(1'b1, 8'd3, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'd3, 8'd3, 1'b0);
      vectors++;
      if (n_swap_count !== exp_n[i] || swap_count !== 16'(i + 1) || n_mismatch !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap[%0d]: n_swap=%0d swap=%0d n_mm=%b, need %0d/%0d/0",
                 i, n_swap_count, swap_count, n_mismatch, exp_n[i], i + 1);
      end
    end
  endtask

  task automatic test_clear_with_en();
    do_clear();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'd9, 8'd9, 1'b0);
    vectors++;
    if (swap_count !== 16'd4) begin
      miscompares++;
      $display("FAIL clear_setup: swap=%0d, need 4", swap_count);
    end
    cycle(1'b1, 8'd9, 8'd9, 1'b1);
    vectors++;
    if (locked !== 1'b0 || swap_count !== 16'd0 || err_count !== 8'd0 || mismatch !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_en: locked=%b swap=%0d err=%0d mm=%b, need 0/0/0/0",
               locked, swap_count, err_count, mismatch);
    end
    cycle(1'b1, 8'd9, 8'd9, 1'b0);
    vectors++;
    if (locked !== 1'b1 || swap_count !== 16'd0) begin
      miscompares++;
      $display("FAIL clear_rearm: locked=%b swap=%0d, need 1/0", locked, swap_count);
    end
    cycle(1'b1, 8'd9, 8'd9, 1'b0);
    vectors++;
    if (swap_count !== 16'd1 || mismatch !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_swap: swap=%0d mm=%b, need 1/0", swap_count, mismatch);
    end
  endtask

`ifdef SWAP_CHK_FIRST_ERR_EN
  task automatic test_first_err();
    do_clear();
    vectors++;
    if (first_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL first_clear: valid=%b, need 0", first_valid);
    end
    cycle(1'b1, 8'd5, 8'd6, 1'b0);
    cycle(1'b1, 8'd7, 8'd8, 1'b0);
    vectors++;
    if (first_valid !== 1'b1 || first_a !== 8'd7 || first_b !== 8'd8 || first_exp_a !== 8'd6) begin
      miscompares++;
      $display("FAIL first_latch: valid=%b a=%0d b=%0d exp=%0d, need 1/7/8/6",
               first_valid, first_a, first_b, first_exp_a);
    end
    cycle(1'b1, 8'd1, 8'd2, 1'b0);
    vectors++;
    if (mismatch !== 1'b1 || first_valid !== 1'b1 || first_a !== 8'd7 ||
        first_b !== 8'd8 || first_exp_a !== 8'd6) begin
      miscompares++;
      $display("FAIL first_hold: mm=%b valid=%b a=%0d b=%0d exp=%0d, need 1/1/7/8/6",
               mismatch, first_valid, first_a, first_b, first_exp_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_swap_chain();
    test_mismatch();
    test_gaps();
    test_saturate();
    test_wrap();
    test_clear_with_en();
`ifdef SWAP_CHK_FIRST_ERR_EN
    test_first_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/swap_checker.md
# swap_checker

Self-checking observer for the pairwise register-swap datapath. Samples an (A, B) register pair on every enabled clock and verifies that each new pair is the exact exchange of the previous one (A_new = B_old, B_new = A_old). Reports per-sample mismatch pulses, a saturating error count and a wrapping good-swap count. Sits beside the swap datapath in simulation and on-chip debug builds.

## Interface
Parameters:
- WIDTH, 8, bit width of each of A and B
- ERR_W, 8, width of err_count (saturating)
- CNT_W, 16, width of swap_count (wrapping)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  sample strobe; a_in/b_in valid this cycle
- a_in  in  WIDTH  observed A register value
- b_in  in  WIDTH  observed B register value
- clear  in  1  synchronous soft restart (same effect as rst)
- locked  out  1  high while a reference pair is held (state ARMED)
- mismatch  out  1  one-cycle pulse: last compared sample was not a swap
- err_count  out  ERR_W  number of mismatches, saturates at all-ones
- swap_count  out  CNT_W  number of verified swaps, wraps modulo 2^CNT_W

## Operation
- Internal state: prev_a, prev_b (WIDTH each), 2-state FSM {IDLE, ARMED}.
- Priority per edge: rst > clear > en. No en: state, registers and counters hold; mismatch = 0.
- IDLE, en=1: capture prev_a<=a_in, prev_b<=b_in; go ARMED; no compare, no count change.
- ARMED, en=1: compare. Match iff a_in==prev_b AND b_in==prev_a.
  - Match: swap_count += 1 (wrap), mismatch <= 0.
  - Mismatch: mismatch <= 1; err_count += 1 unless all-ones (then holds).
  - Either way: prev_a<=a_in, prev_b<=b_in (re-synchronise to latest pair); stay ARMED.
- A==B pair followed by same pair counts as a match (swap of equal values is indistinguishable).
- clear or rst: FSM -> IDLE, prev_a/prev_b/err_count/swap_count/mismatch -> 0.
- clear asserted together with en: clear wins, sample discarded, next en re-arms.

## Timing
- Reset values: locked=0, mismatch=0, err_count=0, swap_count=0 (and first_* = 0 when configured).
- All outputs registered. Sample on edge N: mismatch/counters reflect it after edge N (visible cycle N+1).
- mismatch is exactly one cycle wide per failing sample; back-to-back failing samples give a continuous high.
- locked rises the cycle after the first en following reset/clear.
- First compared sample is the second en after reset/clear; the first is reference only.
- en may be any duty cycle; gaps do not break the chain (compare is against last sampled pair, not last cycle).
- Saturation: err_count at all-ones plus mismatch: stays all-ones, mismatch still pulses.
- Wrap: swap_count at all-ones plus match: becomes 0.

## Configuration
- Macro SWAP_CHK_FIRST_ERR_EN.
- Defined: adds outputs first_valid (1), first_a (WIDTH), first_b (WIDTH), first_exp_a (WIDTH). On the first mismatch after reset/clear, latch observed a_in, b_in and expected A (prev_b); first_valid <= 1; later mismatches do not overwrite. Cleared by rst/clear.
- Undefined: those ports and registers absent; all other behaviour identical.

## Test plan
- Reset then en with (5,6),(6,5),(5,6) -> locked=1 after first sample, swap_count=2, err_count=0, mismatch never high.
- Armed on (5,6), sample (5,6) -> mismatch pulses one cycle, err_count=1; next (6,5) -> match, swap_count=1.
- en gaps: (5,6), 3 idle cycles, (6,5) -> swap_count=1; counters hold during idle cycles.
- ERR_W=2, 4 consecutive non-swaps after arming -> err_count 1,2,3,3; mismatch high all 4 cycles.
- clear together with en=1 (9,9) while ARMED with swap_count=4 -> all counters 0, locked=0, sample ignored; next (9,9),(9,9) -> swap_count=1.
- With SWAP_CHK_FIRST_ERR_EN: (5,6),(7,8),(1,2) -> first_valid=1, first_a=7, first_b=8, first_exp_a=6; unchanged after second mismatch.
